// File: rtl/jt49_bus_master.sv
// rtl/jt49_bus_master.sv - register read/write sequencer for an AY-3-8910 BDIR/BC1/DA bus
// Every bus output is a registered decode of the state, so pins trail the FSM by one clock.
module jt49_bus_master #(
   parameter int STB        = 2,
   parameter int RD_STB     = 4,
   parameter int GAP        = 1,
   parameter int ADDR_CACHE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic       we,
   input  logic [3:0] addr,
   input  logic [7:0] wdata,
   input  logic       flush,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       bdir,
   output logic       bc1,
   output logic [7:0] da_out,
   output logic       da_oe,
   input  logic [7:0] da_in
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      GAP_A,
      WR,
      RD,
      GAP_D,
      DONE
   } state_t;

   localparam logic [7:0] STB_LAST = 8'(STB - 1);
   localparam logic [7:0] RD_LAST  = 8'(RD_STB - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

   state_t     state, state_d;
   logic [7:0] cnt;
   logic       accept;
   logic       hit;

   logic       we_q;
   logic [3:0] addr_q;
   logic [7:0] wdata_q;

   logic       cache_valid;
   logic [3:0] cache_addr;

   logic [1:0] bus_d;
   logic [7:0] da_out_d;
   logic       da_oe_d;
   logic       done_d;

   // busy stays high through the done cycle, so the FSM idling is not enough to accept
   always_comb begin
      accept = (state == IDLE) && !busy && req;
      hit    = (ADDR_CACHE != 0) && cache_valid && (cache_addr == addr);
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!hit)
                  state_d = ADDR;
               else if (we)
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         ADDR:  if (cnt == STB_LAST) state_d = GAP_A;
         GAP_A: if (cnt == GAP_LAST) state_d = we_q ? WR : RD;
         WR:    if (cnt == STB_LAST) state_d = GAP_D;
         RD:    if (cnt == RD_LAST)  state_d = GAP_D;
         GAP_D: if (cnt == GAP_LAST) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_d;
         if (state_d != state || state == IDLE)
            cnt <= 8'd0;
         else
            cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         addr_q  <= 4'h0;
         wdata_q <= 8'h00;
         busy    <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
         end else if (done) begin
            busy    <= 1'b0;
         end
      end
   end

   // flush has priority over the fill at the end of an address phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
         cache_addr  <= 4'h0;
      end else begin
         if (state == ADDR && state_d == GAP_A)
            cache_addr <= addr_q;
         if (flush)
            cache_valid <= 1'b0;
         else if (state == ADDR && state_d == GAP_A)
            cache_valid <= 1'b1;
      end
   end

   always_comb begin
      bus_d    = 2'b00;
      da_out_d = da_out;
      da_oe_d  = 1'b0;
      done_d   = 1'b0;
      case (state)
         ADDR: begin
            bus_d    = 2'b11;
            da_out_d = {4'h0, addr_q};
            da_oe_d  = 1'b1;
         end
         GAP_A: begin
            da_out_d = {4'h0, addr_q};
            da_oe_d  = 1'b1;
         end
         WR: begin
            bus_d    = 2'b10;
            da_out_d = wdata_q;
            da_oe_d  = 1'b1;
         end
         RD: begin
            bus_d    = 2'b01;
         end
         GAP_D: begin
            da_oe_d  = we_q;
         end
         DONE: begin
            done_d   = 1'b1;
         end
         default: begin
            bus_d    = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bdir   <= 1'b0;
         bc1    <= 1'b0;
         da_out <= 8'h00;
         da_oe  <= 1'b0;
         done   <= 1'b0;
      end else begin
         {bdir, bc1} <= bus_d;
         da_out      <= da_out_d;
         da_oe       <= da_oe_d;
         done        <= done_d;
      end
   end

   // the pins still show 01 for one cycle after the FSM leaves RD: that is the last read cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rdata <= 8'h00;
      else if ({bdir, bc1} == 2'b01 && state != RD)
         rdata <= da_in;
   end

endmodule

// File: tb/tb_jt49_bus_master.sv
// tb/tb_jt49_bus_master.sv - bench for jt49_bus_master against a small PSG bus model
module tb_jt49_bus_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req, req_nc, we, flush;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic       busy, done, bdir, bc1, da_oe;
   logic [7:0] rdata, da_out, da_in;
   logic       busy_nc, done_nc, bdir_nc, bc1_nc, da_oe_nc;
   logic [7:0] rdata_nc, da_out_nc;
   logic [7:0] da_in_nc = 8'h00;

   always #5 clk = ~clk;

   jt49_bus_master u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .flush(flush), .busy(busy), .done(done), .rdata(rdata), .bdir(bdir), .bc1(bc1),
      .da_out(da_out), .da_oe(da_oe), .da_in(da_in)
   );

   jt49_bus_master #(.ADDR_CACHE(0)) u_nc (
      .clk(clk), .rst_n(rst_n), .req(req_nc), .we(we), .addr(addr), .wdata(wdata),
      .flush(flush), .busy(busy_nc), .done(done_nc), .rdata(rdata_nc), .bdir(bdir_nc),
      .bc1(bc1_nc), .da_out(da_out_nc), .da_oe(da_oe_nc), .da_in(da_in_nc)
   );

   // PSG-side model: latches the register on 11 with a zero upper nibble, registered read path
   logic [7:0] regs [0:15];
   logic [3:0] lat = 4'h0;
   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 8'h00;
      da_in = 8'hFF;
   end
   always @(posedge clk) begin
      if ({bdir, bc1} == 2'b11 && da_out[7:4] == 4'h0) lat <= da_out[3:0];
      if ({bdir, bc1} == 2'b10) regs[lat] <= da_out;
      da_in <= ({bdir, bc1} == 2'b01) ? regs[lat] : 8'hFF;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   logic [10:0] tr [1:12];
   int dcyc, ndone;

   task automatic txn(input logic t_we, input logic [3:0] t_a, input logic [7:0] t_d,
                      input int xreq, input int xflush);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (busy) chk("idle_wait", 32'(busy), 32'd0);
      we = t_we; addr = t_a; wdata = t_d; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      dcyc = 0; ndone = 0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         req = 1'b0; flush = 1'b0;
         tr[n] = {bdir, bc1, da_oe, da_out};
         if (done) begin
            ndone++;
            if (dcyc == 0) dcyc = n;
         end
         if (n == xreq) begin
            req = 1'b1; addr = 4'h9; we = 1'b1; wdata = 8'hEE;
         end
         if (n == xflush) flush = 1'b1;
      end
   endtask

   // expected pins per cycle from the default timeline: ADDR x2, GAP_A x1, WR x2 / RD x4, GAP_D x1
   task automatic check_txn(input string nm, input logic t_we, input logic [3:0] a,
                            input logic [7:0] d, input logic miss, input logic [7:0] exp_rd);
      logic [10:0] e [1:12];
      logic [10:0] m [1:12];
      int p, bad, edone;
      p = 1;
      if (miss) begin
         for (int i = 0; i < 2; i++) begin e[p] = {3'b111, 4'h0, a}; m[p] = 11'h7FF; p++; end
         e[p] = {3'b001, 4'h0, a}; m[p] = 11'h7FF; p++;
      end
      if (t_we) begin
         for (int i = 0; i < 2; i++) begin e[p] = {3'b101, d}; m[p] = 11'h7FF; p++; end
      end else begin
         for (int i = 0; i < 4; i++) begin e[p] = {3'b010, 8'h00}; m[p] = 11'h700; p++; end
      end
      e[p] = {2'b00, t_we, 8'h00}; m[p] = 11'h700; p++;
      edone = p;
      bad = 0;
      for (int n = 1; n < edone; n++)
         if (bad == 0 && ((tr[n] & m[n]) !== (e[n] & m[n]))) bad = n;
      chk({nm, "_done_cycle"}, 32'(dcyc), 32'(edone));
      chk({nm, "_done_count"}, 32'(ndone), 32'd1);
      chk({nm, "_first_bad_cycle"}, 32'(bad), 32'd0);
      if (!t_we) chk({nm, "_rdata"}, 32'(rdata), 32'(exp_rd));
   endtask

   typedef struct {
      logic       fl;
      logic       we;
      logic [3:0] a;
      logic [7:0] d;
      logic       miss;
      logic [7:0] rd;
   } vec_t;
   vec_t vecs [0:8];

   initial begin
      vecs[0] = '{1'b0, 1'b1, 4'h7, 8'h38, 1'b1, 8'h00};
      vecs[1] = '{1'b0, 1'b1, 4'h7, 8'h3F, 1'b0, 8'h00};
      vecs[2] = '{1'b0, 1'b1, 4'h0, 8'hA5, 1'b1, 8'h00};
      vecs[3] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'hA5};
      vecs[4] = '{1'b1, 1'b1, 4'h7, 8'h38, 1'b1, 8'h00};
      vecs[5] = '{1'b0, 1'b0, 4'h7, 8'h00, 1'b0, 8'h38};
      vecs[6] = '{1'b0, 1'b1, 4'h3, 8'h5C, 1'b1, 8'h00};
      vecs[7] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 8'hA5};
      vecs[8] = '{1'b0, 1'b0, 4'h3, 8'h00, 1'b1, 8'h5C};

      rst_n = 1'b0; req = 1'b0; req_nc = 1'b0; we = 1'b0; flush = 1'b0;
      addr = 4'h0; wdata = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {bdir, bc1, da_oe, busy, done, da_out, rdata}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].fl) begin
            @(negedge clk) flush = 1'b1;
            @(negedge clk) flush = 1'b0;
         end
         txn(vecs[i].we, vecs[i].a, vecs[i].d, 0, 0);
         check_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].a, vecs[i].d,
                   vecs[i].miss, vecs[i].rd);
      end

      // a request during a running write is dropped, not queued
      txn(1'b1, 4'h5, 8'h11, 3, 0);
      check_txn("busy_req", 1'b1, 4'h5, 8'h11, 1'b1, 8'h00);
      chk("busy_req_reg9", 32'(regs[9]), 32'd0);
      chk("rdata_held", 32'(rdata), 32'h5C);
      chk("busy_req_reg5", 32'(regs[5]), 32'h11);

      // flush on the edge that ends ADDR leaves the cache invalid
      txn(1'b1, 4'h4, 8'h42, 0, 1);
      check_txn("flush_at_fill", 1'b1, 4'h4, 8'h42, 1'b1, 8'h00);
      txn(1'b1, 4'h4, 8'h43, 0, 0);
      check_txn("after_flush_fill", 1'b1, 4'h4, 8'h43, 1'b1, 8'h00);

      // reset during WR
      @(negedge clk);
      we = 1'b1; addr = 4'h2; wdata = 8'h77; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_pre_wr", 32'({bdir, bc1}), 32'h2);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_wr", 32'({bdir, bc1, da_oe, busy, done}), 32'd0);
      #3 rst_n = 1'b1;
      txn(1'b1, 4'h2, 8'h77, 0, 0);
      check_txn("rst_after", 1'b1, 4'h2, 8'h77, 1'b1, 8'h00);

      // without the cache every access latches the address
      for (int r = 0; r < 2; r++) begin
         int dn;
         dn = 0;
         @(negedge clk);
         we = 1'b1; addr = 4'h7; wdata = 8'(8'h20 + r); req_nc = 1'b1;
         @(posedge clk); #1;
         req_nc = 1'b0;
         for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n == 1) chk($sformatf("nocache%0d_addr_phase", r), 32'({bdir_nc, bc1_nc, da_out_nc}), 32'h307);
            if (done_nc && dn == 0) dn = n;
         end
         chk($sformatf("nocache%0d_done_cycle", r), 32'(dn), 32'd7);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
